mcs_slot_bridge: RTL and testbench
==================================

MCS_SLOT_BRIDGE -- requirements
Module: mcs_slot_bridge

Interface
REQ-001 SHALL have parameter BRG_BASE, default 32'hC000_0000, bridge window base; only bits [31:24] decoded.
REQ-002 SHALL have parameter NUM_SLOTS, default 2, number of slave chip selects; power of 2, 1..8.
REQ-003 SHALL have parameter SLOT_AW, default 21, word-address width per slot; SLOT_AW+2+log2(NUM_SLOTS) <= 24 (elaboration assertion).
REQ-004 SHALL have parameter TIMEOUT, default 16, max cycles awaiting slave ready; range 2..255.
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  system clock, all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 io_addr_strobe, io_read_strobe, io_write_strobe  in  1 each  MCS bus strobes.
REQ-009 io_byte_enable  in  4  MCS byte lanes.
REQ-010 io_address, io_write_data  in  32 each  MCS address / write data.
REQ-011 io_read_data  out  32  registered read data; io_ready  out  1  one-cycle completion pulse.
REQ-012 slot_cs  out  NUM_SLOTS  one-hot slave select.
REQ-013 fp_wr, fp_rd  out  1 each  one-cycle access pulses.
REQ-014 fp_addr  out  SLOT_AW; fp_wr_data  out  32; fp_be  out  4  latched request fields.
REQ-015 fp_rd_data  in  32*NUM_SLOTS  flattened per-slot read data, slot k at [32k+:32].
REQ-016 fp_ready  in  NUM_SLOTS  per-slot access-complete.
REQ-017 timeout_err  out  1  sticky timeout flag.

Function
REQ-018 Hit SHALL be io_addr_strobe && io_address[31:24]==BRG_BASE[31:24]; misses SHALL be ignored, no response.
REQ-019 Slot index SHALL be io_address[SLOT_AW+2 +: log2(NUM_SLOTS)]; fp_addr SHALL be io_address[SLOT_AW+1:2].
REQ-020 FSM states IDLE, ACCESS, WAIT, RESP; IDLE->ACCESS on hit, latching address, slot, data, byte enables, rd/wr.
REQ-021 In ACCESS (T+1 after strobe) slot_cs[slot] and fp_rd or fp_wr SHALL be high exactly one cycle; slot_cs SHALL stay high through WAIT.
REQ-022 fp_ready[slot] in ACCESS or WAIT SHALL go to RESP, capturing fp_rd_data of that slot (reads) or 0 (writes); otherwise ACCESS->WAIT.
REQ-023 RESP SHALL pulse io_ready one cycle with io_read_data valid, then IDLE; io_read_data SHALL be 0 outside RESP.
REQ-024 Minimum latency: strobe at T, ready in ACCESS -> io_ready at T+2.
REQ-025 Strobes while not IDLE SHALL be ignored; fp_ready of unselected slots SHALL be ignored.
REQ-026 Slots with NUM_SLOTS=2, SLOT_AW=21: slot0 = legacy MMIO region, slot1 = legacy video region.

Reset
REQ-027 rst_n low SHALL force IDLE, clear all latched fields, counter, timeout_err; all outputs 0.
REQ-028 Reset mid-transaction SHALL abort it with no io_ready pulse.

Configuration
REQ-029 Macro MCS_SLOT_BRIDGE_TIMEOUT_EN defined: cycle counter starts in ACCESS; reaching TIMEOUT without fp_ready SHALL enter RESP with io_read_data=32'hDEAD_BEEF and set timeout_err (sticky until reset).
REQ-030 Macro undefined: no counter; WAIT holds indefinitely; timeout_err tied 0.

Structure
REQ-031 Package mcs_bridge_pkg SHALL hold the state enum and constant BRG_TIMEOUT_DATA=32'hDEAD_BEEF.
REQ-032 Sub-module mcs_bridge_timer (load/count/expire) SHALL implement the timeout counter, instantiated only under the macro.

Verification
REQ-033 Read 0xC000_0010, slot0 ready in ACCESS, data 0x1234_5678 -> fp_addr=4, slot_cs=01, io_ready at T+2, io_read_data=0x1234_5678.
REQ-034 Write 0xC080_0004 data 0xA5A5_A5A5 be=4'b0011, slot1 ready after 3 cycles -> slot_cs=10, fp_wr one pulse, fp_be=0011, io_ready at T+5.
REQ-035 Access 0x4000_0000 -> no slot_cs, no fp pulses, no io_ready.
REQ-036 Macro on, TIMEOUT=16, no ready -> io_ready at T+17, data 0xDEAD_BEEF, timeout_err=1 until reset.
REQ-037 rst_n low during WAIT -> outputs 0 immediately, no io_ready; next read completes normally.
REQ-038 Second strobe during WAIT, fp_ready[unselected] high -> both ignored; single io_ready for first access.

Source files
------------

// File: rtl/mcs_bridge_pkg.sv
// mcs_bridge_pkg: shared types and constants for the MCS slot bridge.
package mcs_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } bridge_state_t;

    localparam logic [31:0] BRG_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mcs_bridge_timer.sv
// mcs_bridge_timer: slave-ready watchdog; load clears, count advances,
// expire flags the last allowed cycle of an access.
module mcs_bridge_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire
);

    logic [7:0] cnt_q;

    assign expire = count && (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (count && !expire) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/mcs_slot_bridge.sv
// mcs_slot_bridge: MCS I/O bus to one-hot slave slot bridge.
// Define MCS_SLOT_BRIDGE_TIMEOUT_EN to enable the slave-ready timeout.
module mcs_slot_bridge
    import mcs_bridge_pkg::*;
#(
    parameter logic [31:0] BRG_BASE  = 32'hC000_0000,
    parameter int          NUM_SLOTS = 2,
    parameter int          SLOT_AW   = 21,
    parameter int          TIMEOUT   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    io_addr_strobe,
    input  logic                    io_read_strobe,
    input  logic                    io_write_strobe,
    input  logic [3:0]              io_byte_enable,
    input  logic [31:0]             io_address,
    input  logic [31:0]             io_write_data,
    output logic [31:0]             io_read_data,
    output logic                    io_ready,
    output logic [NUM_SLOTS-1:0]    slot_cs,
    output logic                    fp_wr,
    output logic                    fp_rd,
    output logic [SLOT_AW-1:0]      fp_addr,
    output logic [31:0]             fp_wr_data,
    output logic [3:0]              fp_be,
    input  logic [32*NUM_SLOTS-1:0] fp_rd_data,
    input  logic [NUM_SLOTS-1:0]    fp_ready,
    output logic                    timeout_err
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    if (SLOT_AW + 2 + $clog2(NUM_SLOTS) > 24) begin : g_aw_chk
        $error("SLOT_AW + slot bits exceed the 16 MB window");
    end
    if (NUM_SLOTS < 1 || NUM_SLOTS > 8 ||
        (NUM_SLOTS & (NUM_SLOTS - 1)) != 0) begin : g_ns_chk
        $error("NUM_SLOTS must be a power of 2 in 1..8");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_to_chk
        $error("TIMEOUT must be in 2..255");
    end

    bridge_state_t      state_q, state_d;
    logic [SLOT_AW-1:0] addr_q;
    logic [SW-1:0]      slot_q, slot_d;
    logic [31:0]        wdata_q, rdata_q, resp_data, slot_data;
    logic [3:0]         be_q;
    logic               rd_q, wr_q;
    logic               hit, go, busy, sel_ready, expire, done;
    logic               unused_addr;

    assign unused_addr = ^io_address;

    if (NUM_SLOTS > 1) begin : g_slot
        assign slot_d = io_address[SLOT_AW+2 +: SW];
    end else begin : g_one_slot
        assign slot_d = '0;
    end

    assign hit  = io_addr_strobe && (io_address[31:24] == BRG_BASE[31:24]);
    assign go   = (state_q == ST_IDLE) && hit;
    assign busy = (state_q == ST_ACCESS) || (state_q == ST_WAIT);

    assign sel_ready = fp_ready[slot_q];
    assign slot_data = fp_rd_data[32*slot_q +: 32];
    assign done      = busy && (sel_ready || expire);
    // Slave ready wins over a same-cycle timeout.
    assign resp_data = sel_ready ? (rd_q ? slot_data : '0)
                                 : BRG_TIMEOUT_DATA;

    assign fp_addr    = addr_q;
    assign fp_wr_data = wdata_q;
    assign fp_be      = be_q;

`ifdef MCS_SLOT_BRIDGE_TIMEOUT_EN
    logic err_q;

    mcs_bridge_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state_q == ST_IDLE),
        .count  (busy),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (busy && expire && !sel_ready) begin
            err_q <= 1'b1;
        end
    end

    assign timeout_err = err_q;
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            slot_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (go) begin
                addr_q  <= io_address[SLOT_AW+1:2];
                slot_q  <= slot_d;
                wdata_q <= io_write_data;
                be_q    <= io_byte_enable;
                rd_q    <= io_read_strobe;
                wr_q    <= io_write_strobe;
            end
            if (done) begin
                rdata_q <= resp_data;
            end else if (state_q == ST_RESP) begin
                rdata_q <= '0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_cs      = '0;
        fp_rd        = 1'b0;
        fp_wr        = 1'b0;
        io_ready     = 1'b0;
        io_read_data = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (hit) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                slot_cs = NUM_SLOTS'(1) << slot_q;
                fp_rd   = rd_q;
                fp_wr   = wr_q;
                state_d = done ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                slot_cs = NUM_SLOTS'(1) << slot_q;
                if (done) state_d = ST_RESP;
            end
            ST_RESP: begin
                io_ready     = 1'b1;
                io_read_data = rdata_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mcs_slot_bridge.sv
// tb_mcs_slot_bridge: directed bench with response scoreboard.
module tb_mcs_slot_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_address, io_write_data;
    logic [31:0] io_read_data;
    logic        io_ready;
    logic [1:0]  slot_cs;
    logic        fp_wr, fp_rd;
    logic [20:0] fp_addr;
    logic [31:0] fp_wr_data;
    logic [3:0]  fp_be;
    logic [63:0] fp_rd_data;
    logic [1:0]  fp_ready;
    logic        timeout_err;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   c0;

    mcs_slot_bridge dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_byte_enable  (io_byte_enable),
        .io_address      (io_address),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready),
        .slot_cs         (slot_cs),
        .fp_wr           (fp_wr),
        .fp_rd           (fp_rd),
        .fp_addr         (fp_addr),
        .fp_wr_data      (fp_wr_data),
        .fp_be           (fp_be),
        .fp_rd_data      (fp_rd_data),
        .fp_ready        (fp_ready),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every io_ready must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && io_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_ready got=1 exp=0 cyc=%0d", cyc);
            end
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                assert (io_read_data === e.data) else begin
                    failures++;
                    $error("FAIL resp_data got=%h exp=%h",
                           io_read_data, e.data);
                end
                checks++;
                assert (cyc === e.due) else begin
                    failures++;
                    $error("FAIL resp_cycle got=%0d exp=%0d", cyc, e.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic wr,
                         input logic [31:0] d, input logic [3:0] be);
        io_addr_strobe  = 1'b1;
        io_read_strobe  = !wr;
        io_write_strobe = wr;
        io_address      = a;
        io_write_data   = d;
        io_byte_enable  = be;
    endtask

    task automatic idle_bus();
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_bus();
        io_address     = '0;
        io_write_data  = '0;
        io_byte_enable = '0;
        fp_rd_data     = '0;
        fp_ready       = '0;
        tick();
        tick();
        chk("rst_ready", 32'(io_ready), 32'd0);
        chk("rst_rdata", io_read_data, 32'd0);
        chk("rst_cs", 32'(slot_cs), 32'd0);
        chk("rst_fp_pulse", 32'({fp_rd, fp_wr}), 32'd0);
        chk("rst_fields", 32'(fp_addr) | fp_wr_data | 32'(fp_be), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // read slot0, ready in ACCESS
        c0 = cyc;
        start(32'hC000_0010, 1'b0, 32'h0, 4'hF);
        exp_q.push_back('{32'h1234_5678, c0 + 2});
        tick();
        idle_bus();
        chk("rd_cs", 32'(slot_cs), 32'd1);
        chk("rd_fp_rd", 32'(fp_rd), 32'd1);
        chk("rd_fp_wr", 32'(fp_wr), 32'd0);
        chk("rd_addr", 32'(fp_addr), 32'd4);
        fp_rd_data = {32'h5555_AAAA, 32'h1234_5678};
        fp_ready   = 2'b01;
        tick();
        fp_ready = 2'b00;
        chk("rd_ready", 32'(io_ready), 32'd1);
        chk("rd_data", io_read_data, 32'h1234_5678);
        chk("rd_cs_off", 32'(slot_cs), 32'd0);
        tick();
        chk("rd_ready_end", 32'(io_ready), 32'd0);
        chk("rd_data_zero", io_read_data, 32'd0);

        // write slot1, ready three cycles after ACCESS
        c0 = cyc;
        start(32'hC080_0004, 1'b1, 32'hA5A5_A5A5, 4'b0011);
        exp_q.push_back('{32'h0, c0 + 5});
        tick();
        idle_bus();
        chk("wr_cs", 32'(slot_cs), 32'd2);
        chk("wr_fp_wr", 32'(fp_wr), 32'd1);
        chk("wr_fp_rd", 32'(fp_rd), 32'd0);
        chk("wr_be", 32'(fp_be), 32'b0011);
        chk("wr_wdata", fp_wr_data, 32'hA5A5_A5A5);
        chk("wr_addr", 32'(fp_addr), 32'd1);
        tick();
        chk("wr_pulse_once", 32'(fp_wr), 32'd0);
        chk("wr_cs_hold", 32'(slot_cs), 32'd2);
        tick();
        tick();
        chk("wr_wait_ready", 32'(io_ready), 32'd0);
        fp_ready = 2'b10;
        tick();
        fp_ready = 2'b00;
        chk("wr_ready", 32'(io_ready), 32'd1);
        chk("wr_rdata", io_read_data, 32'd0);
        tick();

        // miss outside the bridge window
        start(32'h4000_0000, 1'b0, 32'h0, 4'hF);
        tick();
        idle_bus();
        chk("miss_cs", 32'(slot_cs), 32'd0);
        chk("miss_fp", 32'({fp_rd, fp_wr}), 32'd0);
        tick();
        tick();
        chk("miss_ready", 32'(io_ready), 32'd0);

        // strobe and foreign ready during WAIT are ignored
        c0 = cyc;
        start(32'hC000_0020, 1'b0, 32'h0, 4'hF);
        exp_q.push_back('{32'h0BAD_F00D, c0 + 4});
        tick();
        idle_bus();
        tick();
        start(32'hC080_0000, 1'b1, 32'h1111_2222, 4'hF);
        fp_ready = 2'b10;
        tick();
        idle_bus();
        chk("ign_cs", 32'(slot_cs), 32'd1);
        chk("ign_fp_wr", 32'(fp_wr), 32'd0);
        chk("ign_addr", 32'(fp_addr), 32'd8);
        chk("ign_ready", 32'(io_ready), 32'd0);
        fp_rd_data = {32'hFFFF_0000, 32'h0BAD_F00D};
        fp_ready   = 2'b01;
        tick();
        fp_ready = 2'b00;
        chk("ign_done", 32'(io_ready), 32'd1);
        tick();
        tick();
        tick();

`ifdef MCS_SLOT_BRIDGE_TIMEOUT_EN
        c0 = cyc;
        start(32'hC000_0000, 1'b0, 32'h0, 4'hF);
        exp_q.push_back('{32'hDEAD_BEEF, c0 + 17});
        tick();
        idle_bus();
        repeat (15) tick();
        chk("to_pending", 32'(io_ready), 32'd0);
        chk("to_err_pre", 32'(timeout_err), 32'd0);
        tick();
        chk("to_ready", 32'(io_ready), 32'd1);
        chk("to_data", io_read_data, 32'hDEAD_BEEF);
        chk("to_err", 32'(timeout_err), 32'd1);
        tick();
        tick();
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
`else
        c0 = cyc;
        start(32'hC000_0000, 1'b0, 32'h0, 4'hF);
        exp_q.push_back('{32'h600D_600D, c0 + 31});
        tick();
        idle_bus();
        repeat (29) tick();
        chk("hold_cs", 32'(slot_cs), 32'd1);
        chk("hold_ready", 32'(io_ready), 32'd0);
        chk("hold_terr", 32'(timeout_err), 32'd0);
        fp_rd_data = {32'h0, 32'h600D_600D};
        fp_ready   = 2'b01;
        tick();
        fp_ready = 2'b00;
        chk("hold_done", 32'(io_ready), 32'd1);
        tick();
`endif

        // reset during WAIT aborts without a response
        start(32'hC080_0008, 1'b0, 32'h0, 4'hF);
        tick();
        idle_bus();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_cs", 32'(slot_cs), 32'd0);
        chk("abort_ready", 32'(io_ready), 32'd0);
        chk("abort_addr", 32'(fp_addr), 32'd0);
        chk("abort_terr", 32'(timeout_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_no_ready", 32'(io_ready), 32'd0);

        c0 = cyc;
        start(32'hC000_0040, 1'b0, 32'h0, 4'hF);
        exp_q.push_back('{32'h7777_1111, c0 + 2});
        tick();
        idle_bus();
        chk("post_cs", 32'(slot_cs), 32'd1);
        fp_rd_data = {32'h0, 32'h7777_1111};
        fp_ready   = 2'b01;
        tick();
        fp_ready = 2'b00;
        chk("post_ready", 32'(io_ready), 32'd1);
        tick();
        tick();

        chk("pending_resp", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
